// File: rtl/ula_seq_pkg.sv
// rtl/ula_seq_pkg.sv - op codes, FSM states and iterative-op decode bounds for ula_seq
package ula_seq_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SLTU = 5'd5,
    OP_XOR  = 5'd6,
    OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,
    OP_SRA  = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIVU = 5'd11,
    OP_REMU = 5'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL  = 2'd0,
    IT_DIVU = 2'd1,
    IT_REMU = 2'd2
  } iter_e;

  localparam logic [4:0] OP_ITER_FIRST = 5'd10;
  localparam logic [4:0] OP_ITER_LAST  = 5'd12;

endpackage

// File: rtl/ula_seq_iter.sv
// rtl/ula_seq_iter.sv - iterative shift-add multiply and restoring divide (divide under ULA_SEQ_DIV_EN)
module ula_seq_iter
  import ula_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  iter_e           mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [CNTW-1:0] cnt,
  output logic [XLEN-1:0] res_nxt
);

  logic [XLEN-1:0] acc, x, y;
  logic [XLEN-1:0] acc_n, x_n, y_n;

`ifdef ULA_SEQ_DIV_EN
  iter_e         mode_q;
  logic [XLEN:0] rem_sh, diff;
  // acc is the partial remainder, x shifts the dividend out and the quotient in
  assign rem_sh = {acc, x[XLEN-1]};
  assign diff   = rem_sh - {1'b0, y};
`endif

  always_comb begin
    acc_n = acc;
    x_n   = x;
    y_n   = y;
`ifdef ULA_SEQ_DIV_EN
    if (mode_q != IT_MUL) begin
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        x_n   = {x[XLEN-2:0], 1'b1};
      end else begin
        acc_n = rem_sh[XLEN-1:0];
        x_n   = {x[XLEN-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (x[0]) acc_n = acc + y;
      x_n = x >> 1;
      y_n = y << 1;
    end
  end

  always_comb begin
    res_nxt = acc_n;
`ifdef ULA_SEQ_DIV_EN
    if (mode_q == IT_DIVU) res_nxt = x_n;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      x   <= '0;
      y   <= '0;
      cnt <= '0;
`ifdef ULA_SEQ_DIV_EN
      mode_q <= IT_MUL;
`endif
    end else if (load) begin
      acc <= '0;
      x   <= (mode == IT_MUL) ? b : a;
      y   <= (mode == IT_MUL) ? a : b;
      cnt <= CNTW'(XLEN);
`ifdef ULA_SEQ_DIV_EN
      mode_q <= mode;
`endif
    end else if (step && cnt != '0) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU with start/busy/done handshake; DIVU/REMU enabled by ULA_SEQ_DIV_EN
module ula_seq
  import ula_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out,
  output logic            zero
);

  localparam int CNTW = $clog2(XLEN) + 1;
  localparam int SHW  = $clog2(XLEN);

  state_e          state_q, state_n;
  logic            iter_req, load, wr;
  iter_e           it_mode;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] iter_res, alu_res, res_d;
  logic [SHW-1:0]  shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    iter_req = 1'b0;
    it_mode  = IT_MUL;
    if (op >= OP_ITER_FIRST && op <= OP_ITER_LAST) begin
      case (op)
        OP_MUL:  begin iter_req = 1'b1; it_mode = IT_MUL;  end
`ifdef ULA_SEQ_DIV_EN
        OP_DIVU: begin iter_req = 1'b1; it_mode = IT_DIVU; end
        OP_REMU: begin iter_req = 1'b1; it_mode = IT_REMU; end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        load    = iter_req;
        state_n = iter_req ? S_CALC : S_DONE;
      end
      S_CALC: if (cnt == CNTW'(1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // results are captured on the edge into DONE so out/zero are valid with done
  assign wr    = (state_q == S_IDLE && start && !iter_req) ||
                 (state_q == S_CALC && cnt == CNTW'(1));
  assign res_d = (state_q == S_CALC) ? iter_res : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out     <= '0;
      zero    <= 1'b1;
    end else begin
      state_q <= state_n;
      if (wr) begin
        out  <= res_d;
        zero <= (res_d == '0);
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  ula_seq_iter #(.XLEN(XLEN), .CNTW(CNTW)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (state_q == S_CALC),
    .mode    (it_mode),
    .a       (a),
    .b       (b),
    .cnt     (cnt),
    .res_nxt (iter_res)
  );

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - scoreboard bench for ula_seq (XLEN=32), honours ULA_SEQ_DIV_EN
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ula_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd5:  return (x < y) ? 32'd1 : 32'd0;
      5'd6:  return x ^ y;
      5'd7:  return x << y[4:0];
      5'd8:  return x >> y[4:0];
      5'd9:  return $unsigned($signed(x) >>> y[4:0]);
      5'd10: begin p = 64'(x) * 64'(y); return p[31:0]; end
`ifdef ULA_SEQ_DIV_EN
      5'd11: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd12: return (y == 0) ? x : x % y;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] o);
    if (o == 5'd10) return 33;
`ifdef ULA_SEQ_DIV_EN
    if (o == 5'd11 || o == 5'd12) return 33;
`endif
    return 1;
  endfunction

  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit inj);
    exp_t        e;
    int          k;
    bit          got;
    logic [31:0] prev;
    e.res = model(o, x, y);
    e.z   = (e.res == 32'd0);
    e.lat = lat_of(o);
    sb.push_back(e);
    prev = out;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    k = 0; got = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      start = inj && (k == 4);
      if (inj && k == 4) begin
        op = 5'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        chk("out_hold", out, prev);
      end
      if (k == 1) chk($sformatf("busy_rise_op%0d", o), 32'(busy), 32'd1);
      if (done) got = 1;
    end
    start = 1'b0;
    chk($sformatf("done_seen_op%0d", o), 32'(got), 32'd1);
    e = sb.pop_front();
    chk($sformatf("lat_op%0d", o), 32'(k), 32'(e.lat));
    chk($sformatf("out_op%0d", o), out, e.res);
    chk($sformatf("zero_op%0d", o), 32'(zero), 32'(e.z));
    @(negedge clk);
    chk($sformatf("done_pulse_op%0d", o), 32'(done), 32'd0);
    chk($sformatf("busy_fall_op%0d", o), 32'(busy), 32'd0);
  endtask

  initial begin
    int  dcnt, dbl;
    bit  prevd, saw;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  out, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_out",  out, 32'd0);
    chk("idle_zero", 32'(zero), 32'd1);

    run_op(5'd0,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(5'd4,  32'hFFFF_FFFF, 32'd0, 0);
    run_op(5'd5,  32'hFFFF_FFFF, 32'd0, 0);
    run_op(5'd9,  32'h8000_0000, 32'h24, 0);
    run_op(5'd8,  32'h8000_0000, 32'h24, 0);
    run_op(5'd7,  32'h0000_0003, 32'hFFFF_FFFF, 0);
    run_op(5'd1,  32'd5, 32'd9, 0);
    run_op(5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(5'd3,  32'hF000_0000, 32'h0000_000F, 0);
    run_op(5'd6,  32'hA5A5_A5A5, 32'hFFFF_0000, 0);
    run_op(5'd10, 32'h0001_0003, 32'h0000_0005, 1);
    run_op(5'd10, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(5'd11, 32'd100, 32'd7, 0);
    run_op(5'd12, 32'd100, 32'd7, 0);
    run_op(5'd11, 32'h1234_5678, 32'd0, 0);
    run_op(5'd12, 32'h1234_5678, 32'd0, 0);
    run_op(5'd11, 32'hFFFF_FFFF, 32'h0001_0000, 0);
    run_op(5'd31, 32'd3, 32'd4, 0);
    run_op(5'd10, 32'd6, 32'd7, 0);

    // abort a multiply mid-flight
    @(negedge clk);
    op = 5'd10; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out",  out, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    run_op(5'd0, 32'd40, 32'd2, 0);

    // start held high: one acceptance every other cycle
    @(negedge clk);
    op = 5'd0; a = 32'd5; b = 32'd7; start = 1'b1;
    dcnt = 0; dbl = 0; prevd = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (done && prevd) dbl++;
      if (done) dcnt++;
      prevd = done;
      if (i == 9) start = 1'b0;
    end
    chk("b2b_done_count", 32'(dcnt), 32'd5);
    chk("b2b_no_double",  32'(dbl), 32'd0);
    chk("b2b_out",        out, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
